// File: rtl/mips_fetch_unit.sv
// MIPS fetch stage: owns the PC, registers RAM words into the IR, and implements the branch delay slot.
// Latency: 1 edge from address to IR; stall holds PC and IR; clk_enable=0 freezes everything except reset.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        stall,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        active,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_FAULT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic        valid_q, valid_d;
  logic        active_q, active_d;
  logic        fault_q, fault_d;

  logic        redirect_eff;
  logic        target_aligned;

  // A redirect belongs to the instruction in the IR, so it only counts once that IR is real and moving.
  assign redirect_eff   = redirect & valid_q & ~stall;
  assign target_aligned = (redirect_target[1:0] == 2'b00);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    ir_pc_d  = ir_pc_q;
    valid_d  = valid_q;
    active_d = active_q;
    fault_d  = fault_q;

    case (state_q)
      S_RUN: begin
        if (!stall) begin
          if (pc_q == HALT_ADDR) begin
            valid_d  = 1'b0;
            active_d = 1'b0;
            state_d  = S_HALTED;
          end else begin
            // The word fetched alongside a redirect is the delay slot and is always issued.
            ir_d    = instr_readdata;
            ir_pc_d = pc_q;
            valid_d = 1'b1;
            if (redirect_eff) begin
              if (target_aligned) begin
                pc_d = redirect_target;
              end else begin
                state_d  = S_FAULT;
                fault_d  = 1'b1;
                active_d = 1'b0;
              end
            end else begin
              pc_d = pc_q + 32'd4;
            end
          end
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_VECTOR;
      ir_q     <= 32'd0;
      ir_pc_q  <= 32'd0;
      valid_q  <= 1'b0;
      active_q <= 1'b1;
      fault_q  <= 1'b0;
    end else if (clk_enable) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ir_pc_q  <= ir_pc_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      fault_q  <= fault_d;
    end
  end

  assign instr_address = pc_q;
  assign instr_out     = ir_q;
  assign pc_out        = ir_pc_q;
  assign instr_valid   = valid_q;
  assign active        = active_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: scoreboard of expected IR captures plus per-scenario checks.
module tb_mips_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        active;
  logic        fault;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] last_instr;
  logic [31:0] last_pc;

  mips_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .clk_enable      (clk_enable),
    .stall           (stall),
    .instr_address   (instr_address),
    .instr_readdata  (instr_readdata),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .instr_valid     (instr_valid),
    .active          (active),
    .fault           (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC00000) return 32'h8C020000;
    return {a[15:0], a[31:16]} ^ 32'h5A5A0000;
  endfunction

  assign instr_readdata = mem_word(instr_address);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clk_enable = 1'b1; stall = 1'b0; redirect = 1'b0;
    tick();
    reset = 1'b0;
    exp_pc = 32'hBFC00000;
    last_instr = 32'd0;
    last_pc = 32'd0;
  endtask

  // One unstalled enabled edge in RUN: the current word must land in the IR.
  task automatic fetch_step(input logic redir, input logic [31:0] tgt);
    exp_t e;
    exp_t got;
    reset = 1'b0; clk_enable = 1'b1; stall = 1'b0;
    redirect = redir; redirect_target = tgt;
    e.instr = mem_word(exp_pc);
    e.pc = exp_pc;
    sb.push_back(e);
    tick();
    redirect = 1'b0;
    got = sb.pop_front();
    checks++;
    if (instr_valid !== 1'b1) begin errors++; $display("FAIL step_valid: got %b expected 1", instr_valid); end
    checks++;
    if (instr_out !== got.instr) begin errors++; $display("FAIL step_instr: got %h expected %h", instr_out, got.instr); end
    checks++;
    if (pc_out !== got.pc) begin errors++; $display("FAIL step_pc_out: got %h expected %h", pc_out, got.pc); end
    last_instr = got.instr;
    last_pc = got.pc;
    exp_pc = redir ? tgt : exp_pc + 32'd4;
    checks++;
    if (instr_address !== exp_pc) begin errors++; $display("FAIL step_addr: got %h expected %h", instr_address, exp_pc); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    do_reset();
    checks++;
    if (instr_address !== 32'hBFC00000) begin errors++; $display("FAIL reset_addr: got %h expected bfc00000", instr_address); end
    checks++;
    if ({instr_out, pc_out} !== 64'd0) begin errors++; $display("FAIL reset_ir: got %h/%h expected 0/0", instr_out, pc_out); end
    checks++;
    if ({instr_valid, active, fault} !== 3'b010) begin errors++; $display("FAIL reset_flags: got %b expected 010", {instr_valid, active, fault}); end
  endtask

  task automatic test_first_fetch();
    fetch_step(1'b0, 32'd0);
  endtask

  task automatic test_branch();
    fetch_step(1'b1, 32'h1FFFFFF8);
    fetch_step(1'b0, 32'd0);
    fetch_step(1'b0, 32'd0);
    fetch_step(1'b1, 32'h2F00F000);
    fetch_step(1'b0, 32'd0);
  endtask

  task automatic test_stall();
    stall = 1'b1; redirect = 1'b1; redirect_target = 32'h3ABCDEF0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({instr_address, instr_out, pc_out, instr_valid, active, fault} !== {exp_pc, last_instr, last_pc, 3'b110}) begin
        errors++;
        $display("FAIL stall_hold: got %h %h %h %b expected %h %h %h 110", instr_address, instr_out, pc_out,
                 {instr_valid, active, fault}, exp_pc, last_instr, last_pc);
      end
    end
    fetch_step(1'b1, 32'h3ABCDEF0);
    fetch_step(1'b0, 32'd0);
  endtask

  task automatic test_clk_enable();
    clk_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stall = 1'($urandom_range(0, 1));
      redirect = 1'($urandom_range(0, 1));
      redirect_target = $urandom() & 32'hFFFFFFFC;
      tick();
      checks++;
      if ({instr_address, instr_out, pc_out, instr_valid, active, fault} !== {exp_pc, last_instr, last_pc, 3'b110}) begin
        errors++;
        $display("FAIL freeze_hold: got %h %h %h %b expected %h %h %h 110", instr_address, instr_out, pc_out,
                 {instr_valid, active, fault}, exp_pc, last_instr, last_pc);
      end
    end
    stall = 1'b0; redirect = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0; clk_enable = 1'b1;
    exp_pc = 32'hBFC00000; last_instr = 32'd0; last_pc = 32'd0;
    checks++;
    if ({instr_address, instr_out, instr_valid} !== {32'hBFC00000, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_disabled: got %h %h %b expected bfc00000 00000000 0", instr_address, instr_out, instr_valid);
    end
  endtask

  // Right after reset the IR is empty, so a redirect must be ignored.
  task automatic test_redirect_invalid();
    exp_t got;
    sb.push_back({mem_word(exp_pc), exp_pc});
    stall = 1'b0; redirect = 1'b1; redirect_target = 32'h30000000;
    tick();
    redirect = 1'b0;
    got = sb.pop_front();
    checks++;
    if ({instr_out, pc_out} !== {got.instr, got.pc}) begin
      errors++; $display("FAIL noredir_ir: got %h/%h expected %h/%h", instr_out, pc_out, got.instr, got.pc);
    end
    last_instr = got.instr; last_pc = got.pc;
    exp_pc = exp_pc + 32'd4;
    checks++;
    if (instr_address !== exp_pc) begin errors++; $display("FAIL noredir_addr: got %h expected %h", instr_address, exp_pc); end
  endtask

  task automatic test_fault();
    exp_t got;
    sb.push_back({mem_word(exp_pc), exp_pc});
    stall = 1'b0; redirect = 1'b1; redirect_target = 32'h2F00F002;
    tick();
    redirect = 1'b0;
    got = sb.pop_front();
    last_instr = got.instr; last_pc = got.pc;
    checks++;
    if ({instr_out, pc_out} !== {got.instr, got.pc}) begin
      errors++; $display("FAIL fault_slot: got %h/%h expected %h/%h", instr_out, pc_out, got.instr, got.pc);
    end
    checks++;
    if ({instr_address, instr_valid, active, fault} !== {exp_pc, 3'b101}) begin
      errors++; $display("FAIL fault_flags: got %h %b expected %h 101", instr_address, {instr_valid, active, fault}, exp_pc);
    end
    for (int i = 0; i < 3; i++) begin
      stall = 1'($urandom_range(0, 1));
      redirect = 1'($urandom_range(0, 1));
      redirect_target = $urandom() & 32'hFFFFFFFC;
      tick();
      checks++;
      if ({instr_address, instr_out, pc_out, instr_valid, active, fault} !== {exp_pc, last_instr, last_pc, 3'b001}) begin
        errors++;
        $display("FAIL fault_hold: got %h %h %h %b expected %h %h %h 001", instr_address, instr_out, pc_out,
                 {instr_valid, active, fault}, exp_pc, last_instr, last_pc);
      end
    end
    stall = 1'b0; redirect = 1'b0;
    do_reset();
    checks++;
    if ({instr_address, fault, active} !== {32'hBFC00000, 2'b01}) begin
      errors++; $display("FAIL fault_reset: got %h %b expected bfc00000 01", instr_address, {fault, active});
    end
  endtask

  task automatic check_halted(input int edges);
    for (int i = 0; i < edges; i++) begin
      if (i > 0) begin
        stall = 1'($urandom_range(0, 1));
        redirect = 1'($urandom_range(0, 1));
        redirect_target = $urandom() & 32'hFFFFFFFC;
      end
      tick();
      checks++;
      if ({instr_address, instr_out, pc_out, instr_valid, active, fault} !== {32'd0, last_instr, last_pc, 3'b000}) begin
        errors++;
        $display("FAIL halt_hold: got %h %h %h %b expected 00000000 %h %h 000", instr_address, instr_out, pc_out,
                 {instr_valid, active, fault}, last_instr, last_pc);
      end
    end
    stall = 1'b0; redirect = 1'b0;
  endtask

  task automatic test_wrap();
    fetch_step(1'b0, 32'd0);
    fetch_step(1'b1, 32'hFFFFFFF8);
    fetch_step(1'b0, 32'd0);
    fetch_step(1'b0, 32'd0);
    check_halted(2);
    do_reset();
  endtask

  task automatic test_halt();
    fetch_step(1'b0, 32'd0);
    fetch_step(1'b1, 32'd0);
    check_halted(11);
  endtask

  initial begin
    exp_pc = 32'hBFC00000;
    last_instr = 32'd0;
    last_pc = 32'd0;
    test_reset();
    test_first_fetch();
    test_branch();
    test_stall();
    test_clk_enable();
    test_redirect_invalid();
    test_fault();
    test_wrap();
    test_halt();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
Instruction fetch stage of the MIPS core. It sits directly upstream of the combinational instruction RAM: it drives `instr_address` and registers the returned `instr_readdata` into an instruction register for decode. It owns the PC and implements the MIPS branch delay slot on redirects from decode/execute. It also provides halt-on-PC-zero (the `jr r0` convention) and a misaligned-target fault.

Parameters:
RESET_VECTOR, 32'hBFC00000, PC value loaded by reset.
HALT_ADDR, 32'h00000000, PC value that ends execution.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
clk_enable  in  1  low = freeze all state (no update at edge).
stall  in  1  high = hold PC and instruction register (downstream back-pressure).
instr_address  out  32  fetch address to instruction RAM; combinationally equal to the PC register.
instr_readdata  in  32  instruction word from RAM, valid in the same cycle as `instr_address`.
redirect  in  1  instruction in IR is a taken branch/jump.
redirect_target  in  32  byte address of the branch/jump target.
instr_out  out  32  instruction register to decode.
pc_out  out  32  address of `instr_out`.
instr_valid  out  1  `instr_out` holds a real fetched instruction.
active  out  1  core running (high until halt or fault).
fault  out  1  misaligned redirect detected.

Behaviour:
- Reset (reset=1 at an edge, regardless of clk_enable):
  - PC=RESET_VECTOR, state=RUN.
  - instr_out=0, pc_out=0, instr_valid=0, active=1, fault=0.
  - Reset mid-operation (any state) discards pending redirect/IR contents.
- Enabled edge means reset=0 and clk_enable=1. With clk_enable=0, no register changes; inputs are ignored.
- States: RUN, HALTED, FAULT. HALTED and FAULT are terminal; the only exit is reset.
- redirect_eff = redirect & instr_valid & ~stall. Redirect is ignored when instr_valid=0 or stall=1; decode holds it until accepted.
- RUN, enabled edge, stall=1: PC, instr_out, pc_out, instr_valid all hold.
- RUN, enabled edge, stall=0, PC != HALT_ADDR:
  - instr_out<=instr_readdata, pc_out<=PC, instr_valid<=1.
  - The word captured at the redirect edge is the delay slot and is always issued.
  - If redirect_eff and redirect_target[1:0]==0: PC<=redirect_target.
  - If redirect_eff and redirect_target[1:0]!=0: PC holds; state<=FAULT, fault<=1, active<=0.
  - Otherwise: PC<=PC+4, modulo 2^32 (32'hFFFFFFFC wraps to 0, which then halts).
- RUN, enabled edge, stall=0, PC==HALT_ADDR: no capture; instr_valid<=0, active<=0, state<=HALTED.
- HALTED/FAULT, enabled edge: instr_valid<=0; PC, instr_out, pc_out, fault hold; stall and redirect ignored.
- Latency:
  - Address to instr_out: 1 edge.
  - Redirect to target on instr_address: 1 edge.
  - Target instruction in IR: 2 edges after the redirect edge.
- Stall and clk_enable both low: stall has no effect and the unit is frozen.
- instr_address is driven purely from the PC register (no combinational path from redirect).

Test Plan:
1. Release reset with RAM returning 32'h8C020000 at BFC00000 -> instr_address=BFC00000, valid=0, active=1. After 1 edge: instr_out=8C020000, pc_out=BFC00000, instr_address=BFC00004, valid=1.
2. IR holds `j` at 1FFFFFFC; redirect=1, target=2F00F000 -> next edge: IR=word@20000000 (delay slot), pc_out=20000000, instr_address=2F00F000. Following edge: IR=word@2F00F000.
3. IR holds `jr r0`; redirect=1, target=0 -> delay slot captured (valid=1). Next edge: valid=0, active=0. Then 10 more edges with random redirect/stall: outputs unchanged.
4. stall=1 for 3 edges with redirect=1, target=3ABCDEF0 -> PC/IR unchanged, redirect not taken. On stall=0: delay slot captured and instr_address=3ABCDEF0.
5. clk_enable=0 for 4 edges mid-run -> all outputs frozen. reset=1 with clk_enable=0 -> reset still applies, instr_address=BFC00000.
6. redirect target 2F00F002 -> fault=1, active=0, delay slot valid for 1 cycle, then valid=0. Reset -> fault=0, PC=BFC00000.
